wb_rmw_seq: RTL and testbench
=============================

WB_RMW_SEQ -- requirements
Module: wb_rmw_seq
Interface
REQ-001 SHALL have parameter DATA_W, default 32: bus data width.
REQ-002 SHALL have parameter SRC_BASE, default 32'h00000000: first read/write-back address.
REQ-003 SHALL have parameter DST_BASE, default 32'h60001004: mirror write address.
REQ-004 SHALL have parameter COUNT, default 1, range 1..65535: words per pass.
REQ-005 SHALL have parameter STRIDE, default 4: byte step between source words.
REQ-006 SHALL have parameter INC, default 1: value added before write-back.
REQ-007 SHALL have parameter START_DLY, default 2, range 0..255: idle cycles before each pass.
REQ-008 SHALL have parameter TIMEOUT, default 1024: cycles allowed per bus cycle awaiting ack.
REQ-009 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-010 sys_rst_n  in  1  reset; synchronous, active-low.
REQ-011 run  in  1  high enables passes; low stops at next pass boundary.
REQ-012 wb_adr_o  out  32  Wishbone address.
REQ-013 wb_dat_o  out  DATA_W  write data.
REQ-014 wb_dat_i  in  DATA_W  read data.
REQ-015 wb_we_o  out  1  write enable.
REQ-016 wb_sel_o  out  DATA_W/8  byte selects, constant all-ones.
REQ-017 wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe, always driven equal.
REQ-018 wb_ack_i  in  1  slave acknowledge.
REQ-019 busy  out  1  high in any state except IDLE and ERR.
REQ-020 pass_cnt  out  16  completed passes, wraps 65535->0.
REQ-021 last_rd  out  DATA_W  most recent read data.
REQ-022 err  out  1  sticky bus timeout flag.
Function
REQ-023 States SHALL be IDLE, DLY, RD, WB, MIR, NEXT, ERR; bus states hold cyc/stb until ack.
REQ-024 IDLE->DLY when run=1; DLY counts START_DLY cycles (0 = one cycle transit), then ->RD with index i=0.
REQ-025 RD: adr=SRC_BASE+i*STRIDE (mod 2^32), we=0; on ack capture wb_dat_i into last_rd and internal d, drop cyc/stb same edge, ->WB.
REQ-026 WB: adr as RD, we=1, dat=d+INC truncated to DATA_W; on ack ->MIR.
REQ-027 MIR: adr=DST_BASE, we=1, dat=d (pre-increment); on ack ->NEXT.
REQ-028 NEXT: if i<COUNT-1, i++ and ->RD; else i=0, pass_cnt++, ->DLY if run=1 else IDLE.
REQ-029 cyc/stb SHALL assert on the edge entering RD/WB/MIR and deassert on the edge sampling ack=1; minimum one idle bus cycle between transactions.
REQ-030 wb_ack_i outside an active cycle SHALL be ignored.
REQ-031 run deassertion mid-pass SHALL NOT abort; pass completes, then IDLE.
REQ-032 wb_adr_o/wb_dat_o/wb_we_o SHALL be stable for the whole cycle.
Reset
REQ-033 sys_rst_n=0 at any edge SHALL force IDLE, cyc=stb=we=0, adr=0, dat=0, i=0, pass_cnt=0, last_rd=0, err=0, busy=0, aborting any bus cycle.
REQ-034 First active edge after sys_rst_n rises SHALL evaluate IDLE transitions.
Configuration
REQ-035 With WB_RMW_SEQ_TIMEOUT_EN defined: per-cycle counter; ack absent for TIMEOUT cycles -> drop cyc/stb, err=1, ->ERR, held until reset.
REQ-036 Without WB_RMW_SEQ_TIMEOUT_EN: no counter, err tied 0, ERR unreachable, sequencer waits indefinitely for ack.
Verification
REQ-037 Defaults, RAM word0=5, run=1 -> read 0x0 returns 5, write 6 to 0x0, write 5 to 0x60001004, pass_cnt=1.
REQ-038 COUNT=3, STRIDE=4, INC=2, RAM {1,2,3} -> RAM {3,4,5}, mirror writes 1,2,3 in order, last_rd=3.
REQ-039 Slave inserts 4 wait states per ack -> cyc/stb held 5 cycles per transaction, data unchanged, no err.
REQ-040 TIMEOUT_EN, TIMEOUT=16, slave never acks -> cyc drops after 16 cycles, err=1, busy=0, no further bus cycles.
REQ-041 sys_rst_n low during WB of pass 3 -> next cycle all outputs at reset values; run=1 restarts at SRC_BASE with pass_cnt=0.

Source files
------------

// File: rtl/wb_rmw_seq_if.sv
// Wishbone master/slave bundle for the read-modify-write sequencer.
// Signal names keep the master-side Wishbone naming (_o = driven by
// master, _i = driven by slave).
//   wb_adr_o  32      address
//   wb_dat_o  DATA_W  write data
//   wb_dat_i  DATA_W  read data
//   wb_we_o   1       write enable
//   wb_sel_o  DATA_W/8 byte selects
//   wb_cyc_o / wb_stb_o  cycle / strobe
//   wb_ack_i  1       slave acknowledge
interface wb_rmw_seq_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_we_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_rmw_seq.sv
// wb_rmw_seq: Wishbone read-modify-write sequencer.
// Each pass walks COUNT words starting at SRC_BASE (STRIDE bytes apart):
// read the word, write back word+INC to the same address, then write the
// original word to DST_BASE. Passes repeat while run is high, each
// preceded by a START_DLY idle window.
//
// Ports:
//   sys_clk    sole clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   run        enable passes; low stops at the next pass boundary
//   wb         Wishbone master modport (wb_rmw_seq_if)
//   busy       high in every state except IDLE and ERR
//   pass_cnt   completed passes (wraps)
//   last_rd    most recent read data
//   err        sticky bus timeout flag
//
// Optional feature: define WB_RMW_SEQ_TIMEOUT_EN to enable the per-cycle
// ack timeout (TIMEOUT cycles -> ERR, held until reset). Without it err is
// tied low and the sequencer waits forever for ack.
module wb_rmw_seq #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [31:0] DST_BASE  = 32'h6000_1004,
  parameter int          COUNT     = 1,
  parameter int          STRIDE    = 4,
  parameter int          INC       = 1,
  parameter int          START_DLY = 2,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run,
  wb_rmw_seq_if.master      wb,
  output logic              busy,
  output logic [15:0]       pass_cnt,
  output logic [DATA_W-1:0] last_rd,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, DLY, RD, WB, MIR, NEXT, ERR} state_t;

  state_t            state, state_n;
  logic              cyc, we;
  logic [31:0]       adr;
  logic [DATA_W-1:0] dat, d;
  logic [15:0]       idx, idx_n;
  logic [7:0]        dly_cnt;
  logic              ack_ok, to_hit, last_word, launch_rd, launch_wr;

  // ack only counts inside an active cycle
  assign ack_ok    = cyc & wb.wb_ack_i;
  assign last_word = (idx == 16'(COUNT - 1));

  // RD launches on the edge that enters it; WB/MIR are entered on the edge
  // that drops the previous cycle, so they launch one cycle later, which
  // gives the mandatory idle bus cycle between transactions.
  assign launch_rd = (state_n == RD) && (state != RD);
  assign launch_wr = ((state == WB) || (state == MIR)) && !cyc;

  always_comb begin
    idx_n = idx;
    if (state == NEXT) idx_n = last_word ? 16'd0 : idx + 16'd1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (run) state_n = DLY;
      // dwell START_DLY+1 cycles; START_DLY=0 is a single transit cycle
      DLY:  if (dly_cnt == 8'(START_DLY)) state_n = RD;
      RD:   if (to_hit) state_n = ERR; else if (ack_ok) state_n = WB;
      WB:   if (to_hit) state_n = ERR; else if (ack_ok) state_n = MIR;
      MIR:  if (to_hit) state_n = ERR; else if (ack_ok) state_n = NEXT;
      NEXT: if (!last_word) state_n = RD;
            else            state_n = run ? DLY : IDLE;
      ERR:  state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cyc      <= 1'b0;
      we       <= 1'b0;
      adr      <= '0;
      dat      <= '0;
      d        <= '0;
      idx      <= '0;
      dly_cnt  <= '0;
      pass_cnt <= '0;
      last_rd  <= '0;
    end else begin
      dly_cnt <= (state == DLY) ? dly_cnt + 8'd1 : 8'd0;
      idx     <= idx_n;
      // address/data/we only change at launch, so they stay stable for the
      // whole cycle; WB reuses the address left by RD
      if (launch_rd) begin
        cyc <= 1'b1;
        we  <= 1'b0;
        adr <= SRC_BASE + 32'(idx_n) * 32'(STRIDE);
      end else if (launch_wr) begin
        cyc <= 1'b1;
        we  <= 1'b1;
        if (state == WB) begin
          dat <= d + DATA_W'(INC);
        end else begin
          adr <= DST_BASE;
          dat <= d;
        end
      end else if (ack_ok || to_hit) begin
        cyc <= 1'b0;
      end
      if ((state == RD) && ack_ok) begin
        d       <= wb.wb_dat_i;
        last_rd <= wb.wb_dat_i;
      end
      if ((state == NEXT) && last_word) pass_cnt <= pass_cnt + 16'd1;
    end
  end

`ifdef WB_RMW_SEQ_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        err_q;

  // cyc stays high for exactly TIMEOUT cycles before being abandoned
  assign to_hit = cyc && !wb.wb_ack_i && (to_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!cyc || wb.wb_ack_i) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 32'd1;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  assign busy        = (state != IDLE) && (state != ERR);
  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = cyc;
  assign wb.wb_adr_o = adr;
  assign wb.wb_dat_o = dat;
  assign wb.wb_we_o  = we;
  assign wb.wb_sel_o = '1;

endmodule

// File: tb/tb_wb_rmw_seq.sv
// Directed bench for wb_rmw_seq: two instances (default config and a
// 3-word config), each with a small RAM slave with programmable wait states.
module tb_wb_rmw_seq;
  localparam logic [31:0] DST = 32'h6000_1004;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic run0 = 1'b0, run1 = 1'b0;
  always #5 sys_clk = ~sys_clk;

  wb_rmw_seq_if #(.DATA_W(32)) bus0 ();
  wb_rmw_seq_if #(.DATA_W(32)) bus1 ();

  logic        busy0, busy1, err0, err1;
  logic [15:0] pc0, pc1;
  logic [31:0] lr0, lr1;

  wb_rmw_seq #(.TIMEOUT(16)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run(run0), .wb(bus0.master),
    .busy(busy0), .pass_cnt(pc0), .last_rd(lr0), .err(err0));

  wb_rmw_seq #(.COUNT(3), .STRIDE(4), .INC(2), .START_DLY(0), .TIMEOUT(16)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run(run1), .wb(bus1.master),
    .busy(busy1), .pass_cnt(pc1), .last_rd(lr1), .err(err1));

  // ---------------- slaves + monitors ----------------
  logic [31:0] ram0 [16];
  logic [31:0] ram1 [16];
  int   ws0 = 0, ws1 = 0, wcnt0 = 0, wcnt1 = 0;
  logic ack_en0 = 1'b1, stray0 = 1'b0;
  logic [31:0] wadr0[$], wdat0[$], radr0[$], wadr1[$], wdat1[$], radr1[$];
  int   len0[$];
  int   cur0 = 0, cur1 = 0, stab0 = 0, stab1 = 0, gap0 = 0, gap1 = 0;
  logic pcyc0 = 1'b0, pack0 = 1'b0, pwe0 = 1'b0, pcyc1 = 1'b0, pack1 = 1'b0, pwe1 = 1'b0;
  logic [31:0] padr0 = '0, pdat0 = '0, padr1 = '0, pdat1 = '0;

  assign bus0.wb_dat_i = ram0[bus0.wb_adr_o[5:2]];
  assign bus0.wb_ack_i = (bus0.wb_cyc_o && bus0.wb_stb_o && ack_en0 && (wcnt0 == ws0)) || stray0;
  assign bus1.wb_dat_i = ram1[bus1.wb_adr_o[5:2]];
  assign bus1.wb_ack_i = bus1.wb_cyc_o && bus1.wb_stb_o && (wcnt1 == ws1);

  always @(posedge sys_clk) begin
    wcnt0 <= (bus0.wb_cyc_o && !bus0.wb_ack_i) ? wcnt0 + 1 : 0;
    if (bus0.wb_cyc_o !== bus0.wb_stb_o) stab0++;
    if (bus0.wb_cyc_o) begin
      if (pcyc0 && pack0) gap0++;
      if (pcyc0 && !pack0 && (bus0.wb_adr_o !== padr0 || bus0.wb_dat_o !== pdat0 || bus0.wb_we_o !== pwe0)) stab0++;
      cur0++;
      if (bus0.wb_ack_i) begin
        len0.push_back(cur0);
        cur0 = 0;
        if (bus0.wb_we_o) begin
          wadr0.push_back(bus0.wb_adr_o);
          wdat0.push_back(bus0.wb_dat_o);
          if (bus0.wb_adr_o < 32'd64) ram0[bus0.wb_adr_o[5:2]] = bus0.wb_dat_o;
        end else radr0.push_back(bus0.wb_adr_o);
      end
    end else cur0 = 0;
    pcyc0 = bus0.wb_cyc_o; pack0 = bus0.wb_ack_i;
    padr0 = bus0.wb_adr_o; pdat0 = bus0.wb_dat_o; pwe0 = bus0.wb_we_o;
  end

  always @(posedge sys_clk) begin
    wcnt1 <= (bus1.wb_cyc_o && !bus1.wb_ack_i) ? wcnt1 + 1 : 0;
    if (bus1.wb_cyc_o !== bus1.wb_stb_o) stab1++;
    if (bus1.wb_cyc_o) begin
      if (pcyc1 && pack1) gap1++;
      if (pcyc1 && !pack1 && (bus1.wb_adr_o !== padr1 || bus1.wb_dat_o !== pdat1 || bus1.wb_we_o !== pwe1)) stab1++;
      cur1++;
      if (bus1.wb_ack_i) begin
        cur1 = 0;
        if (bus1.wb_we_o) begin
          wadr1.push_back(bus1.wb_adr_o);
          wdat1.push_back(bus1.wb_dat_o);
          if (bus1.wb_adr_o < 32'd64) ram1[bus1.wb_adr_o[5:2]] = bus1.wb_dat_o;
        end else radr1.push_back(bus1.wb_adr_o);
      end
    end else cur1 = 0;
    pcyc1 = bus1.wb_cyc_o; pack1 = bus1.wb_ack_i;
    padr1 = bus1.wb_adr_o; pdat1 = bus1.wb_dat_o; pwe1 = bus1.wb_we_o;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_pc(input int which, input logic [15:0] target, input string tag);
    int k = 0;
    while (((which == 0) ? pc0 : pc1) != target && k < 600) begin tick(); k++; end
    chk(tag, (which == 0) ? pc0 : pc1, target);
  endtask

  task automatic wait_idle(input int which, input string tag);
    int k = 0;
    while (((which == 0) ? busy0 : busy1) && k < 600) begin tick(); k++; end
    chk(tag, (which == 0) ? busy0 : busy1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b, k, n, mn, mx;
    logic [31:0] ea [6];
    logic [31:0] ed [6];
    for (int i = 0; i < 16; i++) begin ram0[i] = '0; ram1[i] = '0; end

    // reset state
    sys_rst_n = 1'b0;
    repeat (3) tick();
    chk("rst cyc", bus0.wb_cyc_o, 1'b0);
    chk("rst stb", bus0.wb_stb_o, 1'b0);
    chk("rst we", bus0.wb_we_o, 1'b0);
    chk("rst adr", bus0.wb_adr_o, 32'h0);
    chk("rst dat", bus0.wb_dat_o, 32'h0);
    chk("rst busy", busy0, 1'b0);
    chk("rst pass_cnt", pc0, 16'h0);
    chk("rst last_rd", lr0, 32'h0);
    chk("rst err", err0, 1'b0);
    chk("sel ones", bus0.wb_sel_o, 4'hf);
    sys_rst_n = 1'b1;
    repeat (3) tick();
    chk("idle without run", busy0, 1'b0);

    // default config, single pass; run drops mid-pass so it must finish and idle
    ram0[0] = 32'd5;
    run0 = 1'b1; tick(); run0 = 1'b0;
    wait_pc(0, 16'd1, "t1 pass_cnt");
    wait_idle(0, "t1 idle");
    chk("t1 nreads", radr0.size(), 1);
    chk("t1 rd adr", radr0[0], 32'h0);
    chk("t1 nwrites", wadr0.size(), 2);
    chk("t1 wb adr", wadr0[0], 32'h0);
    chk("t1 wb dat", wdat0[0], 32'd6);
    chk("t1 mir adr", wadr0[1], DST);
    chk("t1 mir dat", wdat0[1], 32'd5);
    chk("t1 last_rd", lr0, 32'd5);
    chk("t1 ram", ram0[0], 32'd6);
    chk("t1 cyc len", len0[0], 1);

    // four wait states per ack
    ws0 = 4; ram0[0] = 32'd10; b = wadr0.size(); n = len0.size();
    run0 = 1'b1; tick(); run0 = 1'b0;
    wait_pc(0, 16'd2, "t2 pass_cnt");
    wait_idle(0, "t2 idle");
    mn = 999; mx = 0;
    for (int i = n; i < len0.size(); i++) begin
      if (len0[i] < mn) mn = len0[i];
      if (len0[i] > mx) mx = len0[i];
    end
    chk("t2 ntrans", len0.size() - n, 3);
    chk("t2 min len", mn, 5);
    chk("t2 max len", mx, 5);
    chk("t2 wb dat", wdat0[b], 32'd11);
    chk("t2 mir dat", wdat0[b+1], 32'd10);
    chk("t2 last_rd", lr0, 32'd10);
    chk("t2 err", err0, 1'b0);

    // COUNT=3 STRIDE=4 INC=2
    ram1[0] = 32'd1; ram1[1] = 32'd2; ram1[2] = 32'd3;
    b = wadr1.size(); n = radr1.size();
    run1 = 1'b1; tick(); run1 = 1'b0;
    wait_pc(1, 16'd1, "t3 pass_cnt");
    wait_idle(1, "t3 idle");
    ea[0] = 32'h0; ea[1] = DST; ea[2] = 32'h4; ea[3] = DST; ea[4] = 32'h8; ea[5] = DST;
    ed[0] = 32'd3; ed[1] = 32'd1; ed[2] = 32'd4; ed[3] = 32'd2; ed[4] = 32'd5; ed[5] = 32'd3;
    chk("t3 nwrites", wadr1.size() - b, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3 wr%0d adr", i), wadr1[b+i], ea[i]);
      chk($sformatf("t3 wr%0d dat", i), wdat1[b+i], ed[i]);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("t3 rd%0d adr", i), radr1[n+i], 32'(4*i));
    chk("t3 ram0", ram1[0], 32'd3);
    chk("t3 ram1", ram1[1], 32'd4);
    chk("t3 ram2", ram1[2], 32'd5);
    chk("t3 last_rd", lr1, 32'd3);

    // continuous run, reset during the write-back of the third pass
    ws1 = 2; run1 = 1'b1;
    wait_pc(1, 16'd3, "t4 pass_cnt pre");
    k = 0;
    while (!(bus1.wb_cyc_o && bus1.wb_we_o && bus1.wb_adr_o != DST) && k < 300) begin tick(); k++; end
    chk("t4 wb seen", bus1.wb_cyc_o && bus1.wb_we_o && bus1.wb_adr_o != DST, 1'b1);
    sys_rst_n = 1'b0;
    tick();
    chk("t4 rst cyc", bus1.wb_cyc_o, 1'b0);
    chk("t4 rst we", bus1.wb_we_o, 1'b0);
    chk("t4 rst adr", bus1.wb_adr_o, 32'h0);
    chk("t4 rst dat", bus1.wb_dat_o, 32'h0);
    chk("t4 rst busy", busy1, 1'b0);
    chk("t4 rst pass_cnt", pc1, 16'h0);
    chk("t4 rst last_rd", lr1, 32'h0);
    n = radr1.size();
    sys_rst_n = 1'b1;
    wait_pc(1, 16'd1, "t4 restart pass_cnt");
    chk("t4 restart rd0", radr1[n], 32'h0);
    chk("t4 restart rd1", radr1[n+1], 32'h4);
    chk("t4 restart rd2", radr1[n+2], 32'h8);
    run1 = 1'b0;
    wait_idle(1, "t4 idle");

    // ack outside a cycle is ignored
    stray0 = 1'b1;
    repeat (4) tick();
    chk("stray cyc", bus0.wb_cyc_o, 1'b0);
    chk("stray busy", busy0, 1'b0);
    chk("stray pass_cnt", pc0, 16'h0);
    stray0 = 1'b0;

    // slave never acks
    ack_en0 = 1'b0;
    run0 = 1'b1; tick(); run0 = 1'b0;
    k = 0;
    while (!bus0.wb_cyc_o && k < 50) begin tick(); k++; end
    chk("noack cyc rise", bus0.wb_cyc_o, 1'b1);
`ifdef WB_RMW_SEQ_TIMEOUT_EN
    n = 0;
    while (bus0.wb_cyc_o && n < 100) begin n++; tick(); end
    chk("timeout cyc len", n, 16);
    chk("timeout err", err0, 1'b1);
    chk("timeout busy", busy0, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (bus0.wb_cyc_o) n++; end
    chk("timeout no bus", n, 0);
    chk("timeout err sticky", err0, 1'b1);
`else
    repeat (40) tick();
    chk("noack cyc held", bus0.wb_cyc_o, 1'b1);
    chk("noack err", err0, 1'b0);
    chk("noack busy", busy0, 1'b1);
`endif
    sys_rst_n = 1'b0; tick();
    chk("final rst err", err0, 1'b0);
    chk("final rst cyc", bus0.wb_cyc_o, 1'b0);
    sys_rst_n = 1'b1; ack_en0 = 1'b1; tick();

    chk("bus0 stability", stab0, 0);
    chk("bus1 stability", stab1, 0);
    chk("bus0 idle gap", gap0, 0);
    chk("bus1 idle gap", gap1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
